pwm_capture: RTL and testbench



---
 rtl/pwm_capture_pkg.sv | 23 ++
 rtl/pwm_capture_edge.sv | 28 ++
 rtl/pwm_capture.sv | 162 ++++++++++++++++
 tb/tb_pwm_capture.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM input-capture peripheral: register offsets,
// register bit positions and the capture FSM state encoding.
package pwm_capture_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h40;
  localparam logic [7:0] ADDR_STATUS = 8'h44;
  localparam logic [7:0] ADDR_PERIOD = 8'h48;
  localparam logic [7:0] ADDR_HIGH   = 8'h4C;
  localparam logic [7:0] ADDR_CNT    = 8'h50;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int STAT_VALID_BIT  = 0;
  localparam int STAT_OVF_BIT    = 1;

  typedef enum logic [1:0] {
    ST_DIS = 2'd0,
    ST_ARM = 2'd1,
    ST_HI  = 2'd2,
    ST_LO  = 2'd3
  } cap_state_t;

endpackage

// File: rtl/pwm_capture_edge.sv
// Brings the asynchronous PWM pin into the apb_pclk domain and flags
// rising/falling edges; both edges see the same pipeline latency.
module pwm_capture_edge (
  input  logic apb_pclk,
  input  logic apb_prst,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge apb_pclk or posedge apb_prst) begin
    if (apb_prst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/pwm_capture.sv
// APB input-capture peripheral measuring PWM period and high time.
// Optional interrupt support is enabled by defining PWM_CAP_IRQ_EN.
module pwm_capture #(
  parameter int CNT_W = 32
) (
  input  logic        apb_pclk,
  input  logic        apb_prst,
  input  logic        apb_psel,
  input  logic [31:0] apb_paddr,
  input  logic        apb_penable,
  input  logic        apb_pwrite,
  input  logic [31:0] apb_pwdata,
  output logic [31:0] apb_prdata,
  input  logic        pwm_in,
  output logic        irq
);

  import pwm_capture_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             rise, fall;
  logic             wr_en, ctrl_wr, stat_wr, en_on, en_off;
  logic             cnt_max;
  cap_state_t       state_q, state_d;
  logic             cnt_clr, cnt_one, cnt_inc, high_cap, meas_cap, ovf_set;
  logic [CNT_W-1:0] cnt_q, high_tmp_q, period_q, high_q;
  logic             ctrl_en_q, irq_en_q, valid_q, ovf_q;
  logic             unused_ok;

  pwm_capture_edge u_edge (
    .apb_pclk (apb_pclk),
    .apb_prst (apb_prst),
    .pwm_in   (pwm_in),
    .rise     (rise),
    .fall     (fall)
  );

  assign wr_en     = apb_psel & apb_penable & apb_pwrite;
  assign ctrl_wr   = wr_en && (apb_paddr[7:0] == ADDR_CTRL);
  assign stat_wr   = wr_en && (apb_paddr[7:0] == ADDR_STATUS);
  assign en_on     = ctrl_wr &&  apb_pwdata[CTRL_EN_BIT];
  assign en_off    = ctrl_wr && !apb_pwdata[CTRL_EN_BIT];
  assign cnt_max   = (cnt_q == '1);
  assign unused_ok = ^{apb_paddr[31:8], apb_pwdata[31:2]};

  always_ff @(posedge apb_pclk or posedge apb_prst) begin
    if (apb_prst) state_q <= ST_DIS;
    else          state_q <= state_d;
  end

  // A disabling CTRL write overrides whatever edge arrives in the same cycle.
  always_comb begin
    state_d = state_q;
    if (en_off) begin
      state_d = ST_DIS;
    end else begin
      case (state_q)
        ST_DIS:  if (en_on) state_d = ST_ARM;
        ST_ARM:  if (rise)  state_d = ST_HI;
        ST_HI:   if (fall) state_d = ST_LO; else if (cnt_max) state_d = ST_ARM;
        ST_LO:   if (rise) state_d = ST_HI; else if (cnt_max) state_d = ST_ARM;
        default: state_d = ST_DIS;
      endcase
    end
  end

  always_comb begin
    cnt_clr  = 1'b0;
    cnt_one  = 1'b0;
    cnt_inc  = 1'b0;
    high_cap = 1'b0;
    meas_cap = 1'b0;
    ovf_set  = 1'b0;
    if (en_off) begin
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_DIS: cnt_clr = 1'b1;
        ST_ARM: cnt_one = rise;
        ST_HI: begin
          if (fall)         begin high_cap = 1'b1; cnt_inc = 1'b1; end
          else if (cnt_max) begin ovf_set  = 1'b1; cnt_clr = 1'b1; end
          else              cnt_inc = 1'b1;
        end
        ST_LO: begin
          if (rise)         begin meas_cap = 1'b1; cnt_one = 1'b1; end
          else if (cnt_max) begin ovf_set  = 1'b1; cnt_clr = 1'b1; end
          else              cnt_inc = 1'b1;
        end
        default: cnt_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge apb_pclk or posedge apb_prst) begin
    if (apb_prst) begin
      cnt_q      <= '0;
      high_tmp_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
    end else begin
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_one) cnt_q <= CNT_ONE;
      else if (cnt_inc) cnt_q <= cnt_q + CNT_ONE;
      if (high_cap) high_tmp_q <= cnt_q;
      if (meas_cap) begin
        period_q <= cnt_q;
        high_q   <= high_tmp_q;
      end
    end
  end

  // Hardware set takes priority over a software write-1-to-clear.
  always_ff @(posedge apb_pclk or posedge apb_prst) begin
    if (apb_prst) begin
      ctrl_en_q <= 1'b0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl_en_q <= apb_pwdata[CTRL_EN_BIT];
      if (meas_cap)                                valid_q <= 1'b1;
      else if (stat_wr && apb_pwdata[STAT_VALID_BIT]) valid_q <= 1'b0;
      if (ovf_set)                                 ovf_q <= 1'b1;
      else if (stat_wr && apb_pwdata[STAT_OVF_BIT])   ovf_q <= 1'b0;
    end
  end

`ifdef PWM_CAP_IRQ_EN
  logic irq_q;

  always_ff @(posedge apb_pclk or posedge apb_prst) begin
    if (apb_prst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= apb_pwdata[CTRL_IRQ_EN_BIT];
      irq_q <= irq_en_q & (valid_q | ovf_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    apb_prdata = '0;
    if (apb_psel && !apb_pwrite) begin
      case (apb_paddr[7:0])
        ADDR_CTRL:   apb_prdata = {30'd0, irq_en_q, ctrl_en_q};
        ADDR_STATUS: apb_prdata = {30'd0, ovf_q, valid_q};
        ADDR_PERIOD: apb_prdata = 32'(period_q);
        ADDR_HIGH:   apb_prdata = 32'(high_q);
        ADDR_CNT:    apb_prdata = 32'(cnt_q);
        default:     apb_prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: a PWM generator drives pwm_in and
// expected PERIOD/HIGH come straight from the generator's period and duty.
module tb_pwm_capture;

  localparam int          CW       = 8;
  localparam logic [31:0] A_CTRL   = 32'h40;
  localparam logic [31:0] A_STATUS = 32'h44;
  localparam logic [31:0] A_PERIOD = 32'h48;
  localparam logic [31:0] A_HIGH   = 32'h4C;
  localparam logic [31:0] A_CNT    = 32'h50;
`ifdef PWM_CAP_IRQ_EN
  localparam logic [31:0] CTRL_ON = 32'h3;
  localparam logic        IRQ_ON  = 1'b1;
`else
  localparam logic [31:0] CTRL_ON = 32'h1;
  localparam logic        IRQ_ON  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pwm_in;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int irq_high_cycles = 0;
  int model_period = 0;

  int gen_period = 10;
  int gen_high   = 3;
  bit gen_run    = 1'b0;
  bit gen_level  = 1'b0;

  pwm_capture #(.CNT_W(CW)) dut (
    .apb_pclk    (clk),
    .apb_prst    (rst),
    .apb_psel    (psel),
    .apb_paddr   (paddr),
    .apb_penable (penable),
    .apb_pwrite  (pwrite),
    .apb_pwdata  (pwdata),
    .apb_prdata  (prdata),
    .pwm_in      (pwm_in),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // PWM source: high for gen_high of every gen_period clocks, restarting on a rise.
  initial begin
    int phase;
    phase  = 0;
    pwm_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (gen_run) begin
        pwm_in = (phase < gen_high);
        phase  = (phase + 1 >= gen_period) ? 0 : phase + 1;
      end else begin
        pwm_in = gen_level;
        phase  = 0;
      end
    end
  end

  always @(negedge clk) if (irq !== 1'b0) irq_high_cycles++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b1; paddr = a;
    #1 d = prdata;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    logic [31:0] d;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      apb_read(A_STATUS, d);
      if (d[0]) begin seen = 1'b1; break; end
    end
  endtask

  task automatic start_pwm(input int p, input int h);
    apb_write(A_CTRL, 32'h0);
    gen_run = 1'b0; gen_level = 1'b0; gen_period = p; gen_high = h;
    apb_write(A_STATUS, 32'h3);
    gen_run = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %0b expected 0", irq); end
    checks++; if (prdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_prdata_idle: got %0h expected 0", prdata); end
    for (int i = 0; i < 5; i++) begin
      apb_read(A_CTRL + 32'(4 * i), d);
      checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_reg_%0h: got %0h expected 0", A_CTRL + 32'(4 * i), d); end
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    apb_read(A_CNT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_cnt_after: got %0h expected 0", d); end
  endtask

  task automatic test_apb();
    logic [31:0] d;
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b1; paddr = A_CTRL; pwdata = 32'hFFFF_FFFF;
    #1;
    checks++; if (prdata !== 32'h0) begin errors++; $display("[TB] FAIL prdata_on_write: got %0h expected 0", prdata); end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    apb_read(A_CTRL, d);
    checks++; if (d !== CTRL_ON) begin errors++; $display("[TB] FAIL ctrl_readback: got %0h expected %0h", d, CTRL_ON); end
    apb_read(32'h0000_0140, d);
    checks++; if (d !== CTRL_ON) begin errors++; $display("[TB] FAIL ctrl_alias: got %0h expected %0h", d, CTRL_ON); end
    apb_read(32'h54, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_54: got %0h expected 0", d); end
    apb_read(32'h3C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_3c: got %0h expected 0", d); end
    apb_write(A_CTRL, 32'h0);
  endtask

  task automatic test_capture_random();
    logic [31:0] d;
    int p, h;
    bit seen;
    for (int t = 0; t < 6; t++) begin
      p = (t == 0) ? 10 : $urandom_range(40, 8);
      h = (t == 0) ? 3  : $urandom_range(p - 1, 1);
      apb_write(A_CTRL, 32'h0);
      gen_run = 1'b0; gen_level = 1'b0; gen_period = p; gen_high = h;
      apb_write(A_STATUS, 32'h3);
      apb_read(A_STATUS, d);
      checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL status_cleared t%0d: got %0h expected 0", t, d); end
      gen_run = 1'b1;
      repeat ($urandom_range(p - 1, 0)) @(negedge clk);
      apb_write(A_CTRL, CTRL_ON);
      wait_valid(3 * p + 20, seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL valid_seen t%0d: got %0b expected 1", t, seen); end
      checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_delay t%0d: got %0b expected 0", t, irq); end
      @(negedge clk);
      #1;
      checks++; if (irq !== IRQ_ON) begin errors++; $display("[TB] FAIL irq_assert t%0d: got %0b expected %0b", t, irq, IRQ_ON); end
      apb_write(A_STATUS, 32'h1);
      apb_read(A_STATUS, d);
      checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL valid_w1c t%0d: got %0h expected 0", t, d); end
      checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_clear t%0d: got %0b expected 0", t, irq); end
      apb_read(A_PERIOD, d);
      checks++; if (d !== 32'(p)) begin errors++; $display("[TB] FAIL period t%0d: got %0d expected %0d", t, d, p); end
      apb_read(A_HIGH, d);
      checks++; if (d !== 32'(h)) begin errors++; $display("[TB] FAIL high t%0d: got %0d expected %0d", t, d, h); end
      wait_valid(p + 10, seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL valid_again t%0d: got %0b expected 1", t, seen); end
      apb_read(A_PERIOD, d);
      checks++; if (d !== 32'(p)) begin errors++; $display("[TB] FAIL period_hold t%0d: got %0d expected %0d", t, d, p); end
      model_period = p;
    end
  endtask

  task automatic test_disable_mid_hi();
    logic [31:0] d;
    int p2, h2;
    bit seen;
    start_pwm(40, 30);
    apb_write(A_CTRL, CTRL_ON);
    wait_valid(150, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL dis_valid_seen: got %0b expected 1", seen); end
    apb_write(A_CTRL, 32'h0);
    apb_read(A_CNT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL cnt_after_disable: got %0d expected 0", d); end
    apb_read(A_PERIOD, d);
    checks++; if (d !== 32'd40) begin errors++; $display("[TB] FAIL dis_period_kept: got %0d expected 40", d); end
    apb_read(A_HIGH, d);
    checks++; if (d !== 32'd30) begin errors++; $display("[TB] FAIL dis_high_kept: got %0d expected 30", d); end
    apb_read(A_STATUS, d);
    checks++; if (d !== 32'h1) begin errors++; $display("[TB] FAIL dis_status_kept: got %0h expected 1", d); end
    repeat (20) @(negedge clk);
    apb_read(A_CNT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL cnt_held_disabled: got %0d expected 0", d); end
    p2 = $urandom_range(30, 10);
    h2 = $urandom_range(p2 - 1, 1);
    start_pwm(p2, h2);
    repeat ($urandom_range(p2 - 1, 0)) @(negedge clk);
    apb_write(A_CTRL, CTRL_ON);
    apb_read(A_PERIOD, d);
    checks++; if (d !== 32'd40) begin errors++; $display("[TB] FAIL reen_period_before: got %0d expected 40", d); end
    wait_valid(3 * p2 + 20, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL reen_valid_seen: got %0b expected 1", seen); end
    apb_read(A_PERIOD, d);
    checks++; if (d !== 32'(p2)) begin errors++; $display("[TB] FAIL reen_period: got %0d expected %0d", d, p2); end
    apb_read(A_HIGH, d);
    checks++; if (d !== 32'(h2)) begin errors++; $display("[TB] FAIL reen_high: got %0d expected %0d", d, h2); end
    model_period = p2;
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    int  max_seen;
    bit  done, seen;
    apb_write(A_CTRL, 32'h0);
    gen_run = 1'b0; gen_level = 1'b0;
    apb_write(A_STATUS, 32'h3);
    apb_write(A_CTRL, CTRL_ON);
    repeat (3) @(negedge clk);
    gen_level = 1'b1;
    max_seen = 0;
    done = 1'b0;
    for (int i = 0; i < 320; i++) begin
      apb_read(A_CNT, d);
      if (int'(d) > max_seen) max_seen = int'(d);
      if (max_seen != 0 && d == 32'h0) begin done = 1'b1; break; end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL ovf_wrap_seen: got %0b expected 1", done); end
    checks++; if (max_seen != (1 << CW) - 1) begin errors++; $display("[TB] FAIL ovf_max_cnt: got %0d expected %0d", max_seen, (1 << CW) - 1); end
    apb_read(A_STATUS, d);
    checks++; if (d !== 32'h2) begin errors++; $display("[TB] FAIL ovf_status: got %0h expected 2", d); end
    checks++; if (irq !== IRQ_ON) begin errors++; $display("[TB] FAIL ovf_irq: got %0b expected %0b", irq, IRQ_ON); end
    apb_read(A_PERIOD, d);
    checks++; if (d !== 32'(model_period)) begin errors++; $display("[TB] FAIL ovf_period_kept: got %0d expected %0d", d, model_period); end
    repeat (5) @(negedge clk);
    apb_read(A_CNT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL ovf_arm_idle: got %0d expected 0", d); end
    gen_level = 1'b0;
    repeat (5) @(negedge clk);
    gen_period = 12; gen_high = 4;
    apb_write(A_STATUS, 32'h3);
    gen_run = 1'b1;
    wait_valid(60, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL ovf_recover_valid: got %0b expected 1", seen); end
    apb_read(A_PERIOD, d);
    checks++; if (d !== 32'd12) begin errors++; $display("[TB] FAIL ovf_recover_period: got %0d expected 12", d); end
    model_period = 12;
  endtask

  task automatic test_reset_mid_lo();
    logic [31:0] d;
    bit seen;
    start_pwm(40, 5);
    apb_write(A_CTRL, CTRL_ON);
    wait_valid(150, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL rst_valid_seen: got %0b expected 1", seen); end
    repeat (10) @(negedge clk);
    checks++; if (irq !== IRQ_ON) begin errors++; $display("[TB] FAIL irq_before_reset: got %0b expected %0b", irq, IRQ_ON); end
    #2 rst = 1'b1;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_in_reset: got %0b expected 0", irq); end
    checks++; if (prdata !== 32'h0) begin errors++; $display("[TB] FAIL prdata_unselected: got %0h expected 0", prdata); end
    for (int i = 0; i < 5; i++) begin
      apb_read(A_CTRL + 32'(4 * i), d);
      checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL midlo_reset_reg_%0h: got %0h expected 0", A_CTRL + 32'(4 * i), d); end
    end
    @(negedge clk) rst = 1'b0;
    repeat (10) @(negedge clk);
    apb_read(A_CNT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL dis_after_reset: got %0d expected 0", d); end
    gen_run = 1'b0;
  endtask

  initial begin
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    rst = 1'b1;
    test_reset();
    test_apb();
    test_capture_random();
    test_disable_mid_hi();
    test_overflow();
    test_reset_mid_lo();
`ifndef PWM_CAP_IRQ_EN
    checks++; if (irq_high_cycles != 0) begin errors++; $display("[TB] FAIL irq_tied_low: got %0d high cycles expected 0", irq_high_cycles); end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
